// File: rtl/mul_iter_32_pkg.sv
// Shared definitions for the iterative 32x32 multiplier: operand width and FSM state encoding.
package mul_iter_32_pkg;

   localparam int MUL_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      NEG_LO = 3'd3,
      NEG_HI = 3'd4,
      DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/mul_iter_32_adder.sv
// Lab 32-bit add-with-carry element; the multiplier's only datapath adder.
module mul_iter_32_adder
   import mul_iter_32_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   output logic [WIDTH-1:0] S,
   output logic             Co
);

   always_comb begin
      {Co, S} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C0};
   end

endmodule

// File: rtl/mul_iter_32.sv
// Iterative shift-and-add multiplier on magnitudes, with a two-pass 64-bit negate for signed results.
// Fixed 35-edge latency from acceptance to done regardless of operands.
module mul_iter_32
   import mul_iter_32_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int ITER  = MUL_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);

   localparam int CW = $clog2(ITER);

   state_t           state, state_next;
   logic [WIDTH-1:0] a_q, b_q, mcand, p_hi, p_lo;
   logic             sgn_q, neg, carry;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] add_a, add_b, add_s;
   logic             add_c0, add_co;

   // Local incrementers for operand magnitude; 0x80000000 maps to itself and is used unsigned.
   always_comb begin
      a_mag = (sgn_q & a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
      b_mag = (sgn_q & b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
   end

   mul_iter_32_adder #(.WIDTH(WIDTH)) u_adder (
      .A  (add_a),
      .B  (add_b),
      .C0 (add_c0),
      .S  (add_s),
      .Co (add_co)
   );

   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_c0 = 1'b0;
      case (state)
         RUN: begin
            add_a = p_hi;
            add_b = p_lo[0] ? mcand : '0;
         end
         NEG_LO: if (neg) begin
            add_a  = ~p_lo;
            add_c0 = 1'b1;
         end
         NEG_HI: if (neg) begin
            add_a  = ~p_hi;
            add_c0 = carry;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = (state == DONE);
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    state_next = RUN;
         RUN:     if (count == CW'(ITER - 1)) state_next = NEG_LO;
         NEG_LO:  state_next = NEG_HI;
         NEG_HI:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         mcand <= '0;
         p_hi  <= '0;
         p_lo  <= '0;
         count <= '0;
         neg   <= 1'b0;
         carry <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (start) begin
               a_q   <= op_a;
               b_q   <= op_b;
               sgn_q <= is_signed;
            end
            LOAD: begin
               mcand <= a_mag;
               p_lo  <= b_mag;
               p_hi  <= '0;
               count <= '0;
               neg   <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            end
            RUN: begin
               // {P_hi,P_lo} <= {Co, S, P_lo[31:1]}
               p_hi  <= {add_co, add_s[WIDTH-1:1]};
               p_lo  <= {add_s[0], p_lo[WIDTH-1:1]};
               count <= count + CW'(1);
            end
            NEG_LO: begin
               if (neg) begin
                  p_lo  <= add_s;
                  carry <= add_co;
               end else begin
                  carry <= 1'b0;
               end
            end
            NEG_HI: if (neg) p_hi <= add_s;
            default: ;
         endcase
      end
   end

   assign prod_hi = p_hi;
   assign prod_lo = p_lo;

endmodule

// File: doc/mul_iter_32.md
Name: mul_iter_32

Overview:
- Iterative 32x32 shift-and-add multiplier for the lab ALU datapath. Produces a 64-bit product for MULT/MULTU, written to HI/LO.
- Sits directly on the team's 32-bit add-with-carry element (ports A, B, C0, S, Co), instantiated once. It feeds the adder's operands and carry-in every cycle and consumes S/Co.
- Fixed latency regardless of operands or signedness, so the controller can stall for a constant count.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the product is 2*WIDTH.
- ITER, 32, number of RUN cycles. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request. Sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned. Captured with start.
- op_a  input  32  multiplicand. Captured with start.
- op_b  input  32  multiplier. Captured with start.
- busy  output  1  high from the accepting edge until done drops
- done  output  1  one-cycle pulse; product valid from this cycle onward
- prod_hi  output  32  product bits 63:32 (HI)
- prod_lo  output  32  product bits 31:0 (LO)

Behaviour:
- One clock; reset is synchronous and active-high. At a rising edge with rst=1, all state returns to reset values regardless of state: state=IDLE, busy=0, done=0, prod_hi=0, prod_lo=0, count=0, neg=0, carry=0.
- Reset mid-operation aborts the operation. No done is produced for the aborted request.
- States: IDLE, LOAD, RUN, NEG_LO, NEG_HI, DONE.
- IDLE:
  - start=1 at edge E0 moves to LOAD and captures op_a, op_b, is_signed. busy=1 from E0.
  - start in any other state is ignored; it is not queued.
- LOAD (1 cycle):
  - mcand <= |op_a|, P_lo <= |op_b|, P_hi <= 0, count <= 0.
  - Absolute value is applied only if is_signed and the operand's bit 31 is set. Negation is ~x+1 via a local incrementer, not the shared adder.
  - |0x80000000| = 0x80000000, treated as unsigned.
  - neg <= is_signed & (op_a[31] ^ op_b[31]).
- RUN (exactly 32 cycles):
  - Adder inputs: A=P_hi, B=(P_lo[0] ? mcand : 0), C0=0.
  - {P_hi,P_lo} <= {Co, S, P_lo[31:1]}.
  - count increments each cycle; leave RUN when count==31.
- NEG_LO:
  - If neg: adder A=~P_lo, B=0, C0=1; P_lo <= S, carry <= Co.
  - Else hold P_lo, carry <= 0.
- NEG_HI:
  - If neg: adder A=~P_hi, B=0, C0=carry; P_hi <= S.
  - Else hold.
  - Two's-complement negation of the full 64 bits is done in two adder passes.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE; busy=0 in IDLE.
- Timing:
  - Accepted at E0; done is high in the cycle following E35.
  - 35 edges from acceptance to done. start may be re-asserted in the cycle after done (IDLE).
- prod_hi/prod_lo are continuous views of P_hi/P_lo:
  - Intermediate values are visible while busy. Consumers sample only on done.
  - Values hold after DONE until the next LOAD.
- Arithmetic:
  - Unsigned result is exact modulo 2^64.
  - Signed result equals the 64-bit two's-complement product for all inputs, including 0x80000000 operands.
- Zero operand with neg=1: negating 0 yields 0, with carry propagated correctly.

Decomposition:
- Shared package or header:
  - State encoding localparams: IDLE=0, LOAD=1, RUN=2, NEG_LO=3, NEG_HI=4, DONE=5.
  - WIDTH constant.
- Sub-module: the existing 32-bit add-with-carry element, instantiated once as the only datapath adder.
- Control FSM and counter stay in this module; no further split.

Test Plan:
- Unsigned 0x00000003 * 0x00000005 → prod_hi=0x00000000, prod_lo=0x0000000F. done is exactly 35 edges after acceptance; busy is high throughout.
- Unsigned 0xFFFFFFFF * 0xFFFFFFFF → prod_hi=0xFFFFFFFE, prod_lo=0x00000001.
- Signed 0xFFFFFFFD (−3) * 0x00000005 → prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFF1. Signed 0xFFFFFFFF * 0xFFFFFFFF → 0x00000000_00000001.
- Signed 0x80000000 * 0x80000000 → prod_hi=0x40000000, prod_lo=0x00000000. Signed 0x00000000 * 0x80000000 → 0x00000000_00000000 (neg=1, zero preserved).
- start pulsed again at cycles 5 and 20 of a busy operation with different operands → ignored. Original product delivered, single done pulse.
- rst asserted at RUN cycle 10, then a new start 2 cycles later with 7*6 (unsigned) → no done for the aborted op; outputs read 0 after reset; new result 0x00000000_0000002A at the correct latency.
